// File: rtl/ofmap_pkg.sv
// Shared types and constants for the output-feature-map writer.
// The OFMAP_RELU_EN build option is consumed in ofmap_writer.sv.
package ofmap_pkg;
  localparam int N_LANE = 16;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 10;
  localparam int LANE_W = 4;
  localparam int ADDR_W = LANE_W + IDX_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [IDX_W-1:0]  idx;
  } ofmap_entry_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} wr_state_t;

  // Negative int8 results clamp to zero.
  function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] d);
    return d[DATA_W-1] ? '0 : d;
  endfunction
endpackage

// File: rtl/ofmap_lane_fifo.sv
// Per-lane synchronous FIFO of ofmap entries; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module ofmap_lane_fifo
  import ofmap_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  ofmap_entry_t i_data,
  output ofmap_entry_t o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PTR_W = $clog2(DEPTH);

  ofmap_entry_t     r_mem [DEPTH];
  logic [PTR_W:0]   r_wptr;
  logic [PTR_W:0]   r_rptr;
  logic             w_pop;
  logic             w_push;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                   (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = r_mem[r_rptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PTR_W-1:0]] <= i_data;
  end
endmodule

// File: rtl/ofmap_writer.sv
// Collects per-lane accumulator results into lane FIFOs and round-robins them
// onto one SRAM write port. Define OFMAP_RELU_EN to clamp negative results to 0.
// Handshake: conv_valid_i has no ready; a result is taken the cycle it is valid
// or, if its lane FIFO is full with no pop that cycle, dropped and flagged.
module ofmap_writer
  import ofmap_pkg::ofmap_entry_t, ofmap_pkg::wr_state_t, ofmap_pkg::IDLE,
         ofmap_pkg::RUN, ofmap_pkg::DRAIN, ofmap_pkg::DONE, ofmap_pkg::DATA_W,
         ofmap_pkg::IDX_W, ofmap_pkg::LANE_W, ofmap_pkg::ADDR_W, ofmap_pkg::relu;
#(
  parameter int N_LANE     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [N_LANE-1:0]              conv_valid_i,
  input  logic [N_LANE-1:0]              conv_last_i,
  input  logic [N_LANE-1:0][DATA_W-1:0]  conv_result_i,
  input  logic [N_LANE-1:0][IDX_W-1:0]   addr_i,
  output logic                           wr_en_o,
  output logic [ADDR_W-1:0]              wr_addr_o,
  output logic [DATA_W-1:0]              wr_data_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           overflow_o,
  output wr_state_t                      state_o
);
  wr_state_t          r_state;
  logic [N_LANE-1:0]  r_last_seen;
  logic [LANE_W-1:0]  r_rr_ptr;
  logic               r_wr_en;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0]  r_wr_data;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;

  logic [N_LANE-1:0]  w_push, w_pop, w_drop, w_full, w_empty;
  ofmap_entry_t       w_din  [N_LANE];
  ofmap_entry_t       w_dout [N_LANE];
  ofmap_entry_t       w_sel;
  logic               w_any;
  logic [LANE_W-1:0]  w_grant;
  logic [LANE_W-1:0]  w_cand;
  logic [DATA_W-1:0]  w_wdata;
  logic               w_run;
  logic               w_active;

  assign w_run    = (r_state == RUN);
  assign w_active = (r_state == RUN) || (r_state == DRAIN);

  for (genvar g = 0; g < N_LANE; g++) begin : g_lane
    assign w_din[g]  = {conv_result_i[g], addr_i[g]};
    assign w_pop[g]  = w_active && w_any && (w_grant == LANE_W'(g));
    assign w_push[g] = w_run && conv_valid_i[g] && (!w_full[g] || w_pop[g]);
    assign w_drop[g] = w_run && conv_valid_i[g] && w_full[g] && !w_pop[g];

    ofmap_lane_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_data  (w_din[g]),
      .o_data  (w_dout[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // First non-empty lane at or after r_rr_ptr, wrapping.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 0; k < N_LANE; k++) begin
      w_cand = LANE_W'((32'(r_rr_ptr) + k) % N_LANE);
      if (!w_any && !w_empty[w_cand]) begin
        w_any   = 1'b1;
        w_grant = w_cand;
      end
    end
  end

  assign w_sel = w_dout[w_grant];

`ifdef OFMAP_RELU_EN
  assign w_wdata = relu(w_sel.data);
`else
  assign w_wdata = w_sel.data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_seen <= '0;
      r_rr_ptr    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_en <= w_active && w_any;
      r_done  <= 1'b0;
      if (w_active && w_any) begin
        r_wr_addr <= {w_grant, w_sel.idx};
        r_wr_data <= w_wdata;
        r_rr_ptr  <= (w_grant == LANE_W'(N_LANE - 1)) ? '0 : w_grant + 1'b1;
      end
      case (r_state)
        IDLE: if (start_i) begin
          r_state     <= RUN;
          r_busy      <= 1'b1;
          r_last_seen <= '0;
          r_ovf       <= 1'b0;
        end
        RUN: begin
          // last is recorded even when its result is dropped, so the layer still ends.
          r_last_seen <= r_last_seen | (conv_valid_i & conv_last_i);
          if (|w_drop) r_ovf <= 1'b1;
          if (&r_last_seen) r_state <= DRAIN;
        end
        DRAIN: if (&w_empty && !w_any) begin
          r_state <= DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wr_en_o    = r_wr_en;
  assign wr_addr_o  = r_wr_addr;
  assign wr_data_o  = r_wr_data;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign overflow_o = r_ovf;
  assign state_o    = r_state;
endmodule

// File: tb/tb_ofmap_writer.sv
// Self-checking bench for ofmap_writer: latency table, scoreboard of expected
// writes from a lane-queue reference, and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_ofmap_writer;
  import ofmap_pkg::*;

  localparam int NL    = 16;
  localparam int DEPTH = 4;
  localparam int EW    = 22;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start_i = 1'b0;
  logic [NL-1:0]        conv_valid_i = '0;
  logic [NL-1:0]        conv_last_i = '0;
  logic [NL-1:0][7:0]   conv_result_i = '0;
  logic [NL-1:0][9:0]   addr_i = '0;
  logic                 wr_en_o;
  logic [13:0]          wr_addr_o;
  logic [7:0]           wr_data_o;
  logic                 busy_o, done_o, overflow_o;
  wr_state_t            state_o;

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ofmap_writer #(.N_LANE(NL), .FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .conv_valid_i  (conv_valid_i),
    .conv_last_i   (conv_last_i),
    .conv_result_i (conv_result_i),
    .addr_i        (addr_i),
    .wr_en_o       (wr_en_o),
    .wr_addr_o     (wr_addr_o),
    .wr_data_o     (wr_data_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overflow_o    (overflow_o),
    .state_o       (state_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference: per-lane queues, round-robin pointer, expected write queue
  logic [17:0]   m_mem [NL][DEPTH];
  int            m_cnt [NL];
  int            m_rr;
  logic          m_ovf;
  logic [EW-1:0] exp_q[$];

  function automatic logic [7:0] exp_relu(input logic [7:0] d);
`ifdef OFMAP_RELU_EN
    return d[7] ? 8'h00 : d;
`else
    return d;
`endif
  endfunction

  task automatic model_step();
    int g;
    logic [17:0] e;
    if (rst) begin
      for (int i = 0; i < NL; i++) m_cnt[i] = 0;
      m_rr = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      if (start_i) m_ovf = 1'b0;
      g = -1;
      for (int k = 0; k < NL; k++)
        if (g < 0 && m_cnt[(m_rr + k) % NL] > 0) g = (m_rr + k) % NL;
      if (g >= 0) begin
        e = m_mem[g][0];
        for (int j = 0; j < DEPTH - 1; j++) m_mem[g][j] = m_mem[g][j+1];
        m_cnt[g]--;
        exp_q.push_back({4'(g), e[9:0], exp_relu(e[17:10])});
        m_rr = (g + 1) % NL;
      end
      for (int i = 0; i < NL; i++) begin
        if (conv_valid_i[i]) begin
          if (m_cnt[i] < DEPTH) begin
            m_mem[i][m_cnt[i]] = {conv_result_i[i], addr_i[i]};
            m_cnt[i]++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    conv_valid_i = '0;
    conv_last_i  = '0;
  endtask

  task automatic start_layer();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("busy_after_start", 32'(busy_o), 1);
    check("ovf_cleared", 32'(overflow_o), 0);
    check("state_run", 32'(state_o), 32'(RUN));
  endtask

  // scoreboard monitor
  int last_wr_cyc = -10;
  int wr_lane_log[$];
  int wr_cyc_log[$];

  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (wr_en_o) begin
        last_wr_cyc = cyc;
        wr_lane_log.push_back(int'(wr_addr_o[13:10]));
        wr_cyc_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got write 0x%0h expected no write", {wr_addr_o, wr_data_o});
        end else begin
          e = exp_q.pop_front();
          check("sb_write", 32'({wr_addr_o, wr_data_o}), 32'(e));
        end
      end
    end
  end

  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (!done_o && n < bound) begin
      tick();
      n++;
    end
    if (!done_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done_o expected done within %0d cycles", name, bound);
    end else begin
      check({name, "_done_lat"}, 32'(cyc), 32'(last_wr_cyc + 1));
      check({name, "_busy_low"}, 32'(busy_o), 0);
      check({name, "_sb_empty"}, 32'(exp_q.size()), 0);
      tick();
      check({name, "_done_pulse"}, 32'(done_o), 0);
      check({name, "_idle"}, 32'(state_o), 32'(IDLE));
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300us");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          lane;
    logic [7:0]  data;
    logic [9:0]  idx;
    logic        last;
    logic [13:0] exp_addr;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t tbl[6];

  initial begin : main
    int first;
    int n;
`ifdef OFMAP_RELU_EN
    tbl[0] = '{3,  8'h05, 10'd7,   1'b1, 14'h0C07, 8'h05};
    tbl[1] = '{0,  8'hF0, 10'h155, 1'b0, 14'h0155, 8'h00};
    tbl[2] = '{15, 8'h7F, 10'h3FF, 1'b0, 14'h3FFF, 8'h7F};
    tbl[3] = '{8,  8'h80, 10'h000, 1'b0, 14'h2000, 8'h00};
    tbl[4] = '{1,  8'h00, 10'h001, 1'b0, 14'h0401, 8'h00};
    tbl[5] = '{10, 8'hFF, 10'h200, 1'b0, 14'h2A00, 8'h00};
`else
    tbl[0] = '{3,  8'h05, 10'd7,   1'b1, 14'h0C07, 8'h05};
    tbl[1] = '{0,  8'hF0, 10'h155, 1'b0, 14'h0155, 8'hF0};
    tbl[2] = '{15, 8'h7F, 10'h3FF, 1'b0, 14'h3FFF, 8'h7F};
    tbl[3] = '{8,  8'h80, 10'h000, 1'b0, 14'h2000, 8'h80};
    tbl[4] = '{1,  8'h00, 10'h001, 1'b0, 14'h0401, 8'h00};
    tbl[5] = '{10, 8'hFF, 10'h200, 1'b0, 14'h2A00, 8'hFF};
`endif

    // reset
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_wr_en", 32'(wr_en_o), 0);
    check("rst_wr_addr", 32'(wr_addr_o), 0);
    check("rst_wr_data", 32'(wr_data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_ovf", 32'(overflow_o), 0);
    check("rst_state", 32'(state_o), 32'(IDLE));

    // all 16 lanes in one cycle, straight after reset so the pointer is 0
    start_layer();
    first = wr_lane_log.size();
    conv_valid_i = '1;
    conv_last_i  = '1;
    for (int i = 0; i < NL; i++) begin
      conv_result_i[i] = 8'($urandom_range(0, 255));
      addr_i[i]        = 10'($urandom_range(0, 1023));
    end
    tick();
    idle_inputs();
    wait_done("all16", 40);
    check("all16_count", 32'(wr_lane_log.size() - first), 16);
    if (wr_lane_log.size() - first == 16) begin
      for (int k = 0; k < 16; k++) check("all16_order", 32'(wr_lane_log[first + k]), 32'(k));
      check("all16_back_to_back", 32'(wr_cyc_log[first + 15] - wr_cyc_log[first]), 15);
    end
    check("all16_no_ovf", 32'(overflow_o), 0);

    // single-lane latency table
    start_layer();
    for (int i = 0; i < 6; i++) begin
      conv_valid_i[tbl[i].lane]  = 1'b1;
      conv_last_i[tbl[i].lane]   = tbl[i].last;
      conv_result_i[tbl[i].lane] = tbl[i].data;
      addr_i[tbl[i].lane]        = tbl[i].idx;
      tick();
      idle_inputs();
      tick();
      check("tbl_wr_en", 32'(wr_en_o), 1);
      check("tbl_wr_addr", 32'(wr_addr_o), 32'(tbl[i].exp_addr));
      check("tbl_wr_data", 32'(wr_data_o), 32'(tbl[i].exp_data));
    end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("start_ignored_in_run", 32'(state_o), 32'(RUN));
    conv_valid_i = '1;
    conv_last_i  = '1;
    for (int i = 0; i < NL; i++) begin
      conv_result_i[i] = 8'h00;
      addr_i[i]        = 10'h000;
    end
    tick();
    idle_inputs();
    wait_done("single", 40);

    // overflow: lane 5 hammered while every other lane is backed up
    start_layer();
    for (int c = 0; c < 20; c++) begin
      conv_valid_i = (c < 4) ? 16'hFFFF : 16'h0020;
      conv_last_i  = (c == 3) ? 16'hFFDF : ((c == 19) ? 16'h0020 : 16'h0000);
      for (int i = 0; i < NL; i++) begin
        conv_result_i[i] = 8'($urandom_range(0, 255));
        addr_i[i]        = 10'(c * 16 + i);
      end
      tick();
    end
    idle_inputs();
    check("ovf_set", 32'(overflow_o), 1);
    check("ovf_ref_agrees", 32'(m_ovf), 1);
    wait_done("ovf", 200);
    check("ovf_sticky", 32'(overflow_o), 1);

    // fairness: lanes 1 and 2 both kept non-empty
    start_layer();
    first = wr_lane_log.size();
    for (int c = 0; c < 4; c++) begin
      conv_valid_i = 16'h0006;
      conv_last_i  = (c == 3) ? 16'h0006 : 16'h0000;
      for (int i = 1; i <= 2; i++) begin
        conv_result_i[i] = 8'($urandom_range(0, 255));
        addr_i[i]        = 10'(c);
      end
      tick();
    end
    idle_inputs();
    repeat (8) tick();
    check("fair_count", 32'(wr_lane_log.size() - first), 8);
    if (wr_lane_log.size() - first >= 8) begin
      for (int k = 0; k < 8; k++) begin
        check("fair_lane", 32'(wr_lane_log[first + k] == 1 || wr_lane_log[first + k] == 2), 1);
        if (k > 0)
          check("fair_alternate", 32'(wr_lane_log[first + k] != wr_lane_log[first + k - 1]), 1);
      end
    end
    conv_valid_i = ~16'h0006;
    conv_last_i  = ~16'h0006;
    tick();
    idle_inputs();
    wait_done("fair", 40);

    // reset asserted in DRAIN with entries still queued
    start_layer();
    for (int c = 0; c < 3; c++) begin
      conv_valid_i = '1;
      conv_last_i  = (c == 2) ? 16'hFFFF : 16'h0000;
      for (int i = 0; i < NL; i++) begin
        conv_result_i[i] = 8'($urandom_range(0, 255));
        addr_i[i]        = 10'($urandom_range(0, 1023));
      end
      tick();
    end
    idle_inputs();
    n = 0;
    while (state_o != DRAIN && n < 20) begin
      tick();
      n++;
    end
    check("mid_reached_drain", 32'(state_o), 32'(DRAIN));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_wr_en", 32'(wr_en_o), 0);
    check("mid_rst_wr_addr", 32'(wr_addr_o), 0);
    check("mid_rst_wr_data", 32'(wr_data_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_ovf", 32'(overflow_o), 0);
    check("mid_rst_state", 32'(state_o), 32'(IDLE));
    tick();
    check("mid_rst_quiet", 32'(wr_en_o), 0);

    start_layer();
    first = wr_lane_log.size();
    conv_valid_i = '1;
    conv_last_i  = '1;
    for (int i = 0; i < NL; i++) begin
      conv_result_i[i] = 8'(i * 7);
      addr_i[i]        = 10'(i + 100);
    end
    tick();
    idle_inputs();
    wait_done("post_rst", 40);
    check("post_rst_count", 32'(wr_lane_log.size() - first), 16);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
